// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified memory-port arbiter and its LL/SC reservation tracker.
package cpu_mem_pkg;

   typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, RESP} arb_state_t;
   typedef enum logic {REQ_IF, REQ_MEM} requester_t;

   localparam logic [3:0] WORD_MASK_ALL = 4'b1111;

endpackage

// File: rtl/llsc_resv.sv
// Single LL/SC reservation register at word granularity with address compare.
module llsc_resv #(
   parameter int AW = 30
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set,
   input  logic          clear,
   input  logic          store_done,
   input  logic [AW-1:0] addr,
   output logic          resv_valid,
   output logic          addr_match
);

   logic [AW-1:0] resvAddr;

   assign addr_match = (addr == resvAddr);

   // Clear wins over set; a plain store only kills a reservation on its own word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resv_valid <= 1'b0;
         resvAddr   <= '0;
      end else if (clear) begin
         resv_valid <= 1'b0;
      end else if (set) begin
         resv_valid <= 1'b1;
         resvAddr   <= addr;
      end else if (store_done && addr_match) begin
         resv_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and data access,
// with starvation protection for fetch and LL/SC store-conditional resolution.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [31:0]       if_rdata,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic              mem_atomic,
   input  logic [3:0]        mem_mask,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic              mem_sc_ok,
   output logic              bus_valid,
   output logic              bus_we,
   output logic [3:0]        bus_mask,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ready,
   input  logic [31:0]       bus_rdata
);

   arb_state_t          state, nextState;
   requester_t          grantee;
   logic [3:0]          starveCnt;
   logic                curLl, curSc, scOkR;
   logic [31:0]         ifRdataR, memRdataR;
   logic                busWeR;
   logic [3:0]          busMaskR;
   logic [ADDR_W-1:0]   busAddrR;
   logic [31:0]         busWdataR;
   logic                scReq, forceIf, grantMem, grantIf, scFail, scPass;
   logic                resvValid, resvMatch, resvSet, resvClear, storeDone;
   logic [ADDR_W-3:0]   resvAddrIn;

   // The reservation is queried with the live request in IDLE, updated with the held bus address later.
   assign resvAddrIn = (state == IDLE) ? mem_addr[ADDR_W-1:2] : busAddrR[ADDR_W-1:2];

   always_comb begin
      scReq    = mem_req && mem_we && mem_atomic;
      forceIf  = if_req && (starveCnt == 4'(STARVE_LIMIT));
      grantMem = (state == IDLE) && mem_req && !forceIf;
      grantIf  = (state == IDLE) && if_req && !grantMem;
      scPass   = resvValid && resvMatch;
      scFail   = grantMem && scReq && !scPass;
   end

   always_comb begin
      resvSet   = (state == BUS_MEM) && bus_ready && curLl;
      storeDone = (state == BUS_MEM) && bus_ready && busWeR && !curSc;
      resvClear = grantMem && scReq;
   end

   llsc_resv #(.AW(ADDR_W-2)) u_resv (
      .clk        (clk),
      .rst        (rst),
      .set        (resvSet),
      .clear      (resvClear),
      .store_done (storeDone),
      .addr       (resvAddrIn),
      .resv_valid (resvValid),
      .addr_match (resvMatch)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (grantMem)     nextState = scFail ? RESP : BUS_MEM;
            else if (grantIf) nextState = BUS_IF;
         end
         BUS_IF, BUS_MEM: if (bus_ready) nextState = RESP;
         RESP:            nextState = IDLE;
         default:         nextState = IDLE;
      endcase
   end

   // Grant capture: bus fields are frozen here and held until the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grantee   <= REQ_IF;
         starveCnt <= '0;
         curLl     <= 1'b0;
         curSc     <= 1'b0;
         scOkR     <= 1'b0;
         busWeR    <= 1'b0;
         busMaskR  <= '0;
         busAddrR  <= '0;
         busWdataR <= '0;
         ifRdataR  <= '0;
         memRdataR <= '0;
      end else begin
         if (grantMem) begin
            grantee   <= REQ_MEM;
            busWeR    <= mem_we;
            busMaskR  <= mem_mask;
            busAddrR  <= mem_addr;
            busWdataR <= mem_wdata;
            curLl     <= mem_atomic && !mem_we;
            curSc     <= scReq;
            scOkR     <= scReq && scPass;
            if (scFail) memRdataR <= '0;
            if (if_req) starveCnt <= (starveCnt == 4'hF) ? starveCnt : starveCnt + 4'd1;
         end else if (grantIf) begin
            grantee   <= REQ_IF;
            busWeR    <= 1'b0;
            busMaskR  <= WORD_MASK_ALL;
            busAddrR  <= if_addr;
            busWdataR <= '0;
            curLl     <= 1'b0;
            curSc     <= 1'b0;
            scOkR     <= 1'b0;
            starveCnt <= '0;
         end
         if (bus_ready && (state == BUS_IF))  ifRdataR  <= bus_rdata;
         if (bus_ready && (state == BUS_MEM)) memRdataR <= bus_rdata;
      end
   end

   assign bus_valid = (state == BUS_IF) || (state == BUS_MEM);
   assign bus_we    = busWeR;
   assign bus_mask  = busMaskR;
   assign bus_addr  = busAddrR;
   assign bus_wdata = busWdataR;
   assign if_ready  = (state == RESP) && (grantee == REQ_IF);
   assign mem_ready = (state == RESP) && (grantee == REQ_MEM);
   assign mem_sc_ok = mem_ready && scOkR;
   assign if_rdata  = ifRdataR;
   assign mem_rdata = memRdataR;

endmodule
